sd_extract: RTL and testbench
=============================

Name: sd_extract

Overview:
- Sideband header extractor on the TX Ethernet hardened path, sitting directly upstream of the sideband store-and-forward stage.
- Parses each incoming packet word stream on clk_wr and pulls frame/slot/symbol/exponent fields from a fixed header word.
- Emits one sideband record per packet as an sop pulse carrying the fields and an eop pulse at the packet end.
- Checks packet length; on error it requests a restart so the downstream block discards the partial block.

Parameters:
- DATA_WIDTH, 64, input word bit width.
- FIELD_WORD, 1, word index (0-based) holding the sideband fields.
- PKT_LEN, 16, expected packet length in words; must be >= FIELD_WORD+1.
- WCNT_WIDTH, 12, word counter width; must represent PKT_LEN.
- FRAME_LSB, 54, LSB of frame[9:0] in the field word.
- SLOT_LSB, 46, LSB of slot[7:0].
- SYMBOL_LSB, 42, LSB of symbol[3:0].
- EXP_LSB, 36, LSB of exp[5:0].

Ports:
- clk_wr  in  1  write clock, posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_sop  in  1  input start of packet, qualified by in_valid.
- in_eop  in  1  input end of packet, qualified by in_valid.
- in_data  in  DATA_WIDTH  input word.
- sd_ready  in  1  downstream din_ready.
- sd_valid  out  1  sideband valid pulse.
- sd_sop  out  1  sideband start of packet; fields valid.
- sd_eop  out  1  sideband end of packet.
- sd_restart  out  1  downstream restart pulse.
- sd_exp  out  6  exponent.
- sd_symbol  out  4  symbol index.
- sd_slot  out  8  slot index.
- sd_frame  out  10  frame index.
- pkt_cnt  out  32  packets forwarded with good length.
- drop_cnt  out  32  packets dropped because sd_ready was low.
- err_cnt  out  32  length or framing errors.

Behaviour:
- Reset: all outputs, counters and field registers are 0; FSM is IDLE; word counter wcnt is 0.
- FSM state IDLE:
  - in_valid & in_sop moves to HDR with wcnt=1.
  - If FIELD_WORD==0, the sop word is also the field word and is handled as below.
  - in_valid words without sop are ignored.
- FSM state HDR:
  - Each in_valid increments wcnt.
  - Field-word beat with sd_ready=1: latch the fields and go to BODY. Next cycle sd_valid=sd_sop=1 for exactly one cycle.
  - Field-word beat with sd_ready=0: go to DROP, drop_cnt+1, no sideband output for this packet.
  - in_eop before the field word: err_cnt+1, return to IDLE, no output.
- FSM state BODY:
  - Counts words. On the in_eop beat, the next cycle has sd_valid=sd_eop=1.
  - If the final wcnt equals PKT_LEN: pkt_cnt+1.
  - Otherwise: err_cnt+1 and sd_restart=1 in the same cycle as sd_eop.
  - Return to IDLE.
  - If wcnt would exceed PKT_LEN without eop: at word PKT_LEN+1, pulse sd_eop together with sd_restart, err_cnt+1, go to DROP.
- FSM state DROP: discards words until in_eop, then IDLE. No outputs.
- Field word equal to the eop word (PKT_LEN==FIELD_WORD+1):
  - sd_sop and sd_eop are asserted in the same cycle with sd_valid=1.
  - pkt_cnt+1.
- New in_sop while in HDR, BODY or DROP (missing eop):
  - err_cnt+1.
  - If in BODY, pulse sd_restart next cycle; no sd_eop.
  - Restart parsing with this word as word 0.
- Latency: registered outputs, 1 clk_wr after the triggering input beat.
- Pulse relations: sd_sop, sd_eop and sd_restart are 0 whenever sd_valid=0, except that sd_restart may assert alone on a missing-eop abort.
- Field hold: field outputs keep their last latched values between packets.
- Counters: 32-bit, wrap at 2^32-1 to 0.
- sd_ready: sampled only on the field-word beat; ignored at eop.

Decomposition:
- Shared package tx_eth_pkg:
  - FSM state enum: IDLE, HDR, BODY, DROP.
  - Field width constants: EXP_W=6, SYM_W=4, SLOT_W=8, FRAME_W=10.
  - Sideband record struct {exp, symbol, slot, frame}.
- Sub-module: none required. Optionally one generic sd_err_cnt (32-bit wrapping event counter) instantiated three times.

Test Plan:
- Nominal packet: PKT_LEN=16, FIELD_WORD=1, sd_ready=1, word1 holds frame=0x155, slot=0x3C, symbol=0x7, exp=0x2A.
  - Cycle after word1: sd_sop=1 with those field values.
  - Cycle after word15: sd_eop=1.
  - pkt_cnt=1, err_cnt=0.
- Drop: sd_ready=0 on word1 of a 16-word packet.
  - No sd_valid for the whole packet; drop_cnt=1.
  - Next packet with sd_ready=1 is forwarded normally.
- Short and long packets:
  - Eop at word 9: sd_eop plus sd_restart; err_cnt=1.
  - 20-word packet: sd_eop plus sd_restart after word 16; remaining 3 words discarded; err_cnt=2.
- Missing eop: sop arrives at word 5 of the packet in BODY.
  - sd_restart pulse with no sd_eop; err_cnt+1.
  - New packet parsed from that sop and completes with pkt_cnt+1.
- Header-only packet: PKT_LEN=2, eop on word1.
  - sd_sop=sd_eop=sd_valid=1 in the same cycle; pkt_cnt=1.
- Reset mid-packet: assert rst_n=0 in BODY.
  - All outputs 0 immediately.
  - After release, words before the next sop are ignored; the next packet is processed cleanly.

Source files
------------

// File: rtl/tx_eth_pkg.sv
// Shared types for the TX Ethernet sideband path: parser states and the
// sideband record carried from the header word to the store-and-forward stage.
package tx_eth_pkg;

    localparam int EXP_W   = 6;
    localparam int SYM_W   = 4;
    localparam int SLOT_W  = 8;
    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY,
        DROP
    } state_t;

    typedef struct packed {
        logic [EXP_W-1:0]   exp;
        logic [SYM_W-1:0]   symbol;
        logic [SLOT_W-1:0]  slot;
        logic [FRAME_W-1:0] frame;
    } sd_rec_t;

endpackage

// File: rtl/sd_err_cnt.sv
// Generic wrapping event counter: advances by one on every cycle inc is high.
module sd_err_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk_wr,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sd_extract.sv
// Sideband header extractor: pulls frame/slot/symbol/exp from the field word
// of each packet and emits sop/eop/restart pulses for the downstream store.
module sd_extract
    import tx_eth_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIELD_WORD = 1,
    parameter int PKT_LEN    = 16,
    parameter int WCNT_WIDTH = 12,
    parameter int FRAME_LSB  = 54,
    parameter int SLOT_LSB   = 46,
    parameter int SYMBOL_LSB = 42,
    parameter int EXP_LSB    = 36
) (
    input  logic                  clk_wr,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  sd_ready,
    output logic                  sd_valid,
    output logic                  sd_sop,
    output logic                  sd_eop,
    output logic                  sd_restart,
    output logic [EXP_W-1:0]      sd_exp,
    output logic [SYM_W-1:0]      sd_symbol,
    output logic [SLOT_W-1:0]     sd_slot,
    output logic [FRAME_W-1:0]    sd_frame,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           err_cnt
);

    localparam logic [WCNT_WIDTH-1:0] FIELD_IDX = WCNT_WIDTH'(FIELD_WORD);
    localparam logic [WCNT_WIDTH-1:0] LEN       = WCNT_WIDTH'(PKT_LEN);

    state_t                  state_reg, state_next;
    logic [WCNT_WIDTH-1:0]   wcnt_reg, wcnt_next;
    sd_rec_t                 rec_reg, rec_next;
    logic                    valid_reg, valid_next;
    logic                    sop_reg, sop_next;
    logic                    eop_reg, eop_next;
    logic                    restart_reg, restart_next;
    logic                    hdr_beat;
    logic [WCNT_WIDTH-1:0]   idx;
    logic [WCNT_WIDTH-1:0]   idx_inc;
    logic [WCNT_WIDTH-1:0]   wcnt_inc;
    logic [2:0]              cnt_inc;
    logic [31:0]             cnt_val [3];
    sd_rec_t                 field_rec;
    logic                    unused_data;

    assign unused_data     = ^in_data;
    assign field_rec.frame  = in_data[FRAME_LSB +: FRAME_W];
    assign field_rec.slot   = in_data[SLOT_LSB +: SLOT_W];
    assign field_rec.symbol = in_data[SYMBOL_LSB +: SYM_W];
    assign field_rec.exp    = in_data[EXP_LSB +: EXP_W];
    assign wcnt_inc         = wcnt_reg + 1'b1;
    assign idx_inc          = idx + 1'b1;

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            wcnt_reg    <= '0;
            rec_reg     <= '0;
            valid_reg   <= 1'b0;
            sop_reg     <= 1'b0;
            eop_reg     <= 1'b0;
            restart_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            rec_reg     <= rec_next;
            valid_reg   <= valid_next;
            sop_reg     <= sop_next;
            eop_reg     <= eop_next;
            restart_reg <= restart_next;
        end
    end

    // cnt_inc: [0] good packet, [1] dropped on back-pressure, [2] error
    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        rec_next     = rec_reg;
        valid_next   = 1'b0;
        sop_next     = 1'b0;
        eop_next     = 1'b0;
        restart_next = 1'b0;
        cnt_inc      = 3'b000;
        hdr_beat     = 1'b0;
        idx          = wcnt_reg;

        if (in_valid) begin
            if (in_sop) begin
                // Any sop restarts parsing at word 0; one mid-packet means eop was lost
                hdr_beat = 1'b1;
                idx      = '0;
                if (state_reg != IDLE) cnt_inc[2] = 1'b1;
                if (state_reg == BODY) restart_next = 1'b1;
            end else begin
                case (state_reg)
                    HDR: hdr_beat = 1'b1;
                    BODY: begin
                        wcnt_next = wcnt_inc;
                        if (in_eop) begin
                            valid_next = 1'b1;
                            eop_next   = 1'b1;
                            state_next = IDLE;
                            wcnt_next  = '0;
                            if (wcnt_inc == LEN) begin
                                cnt_inc[0] = 1'b1;
                            end else begin
                                restart_next = 1'b1;
                                cnt_inc[2]   = 1'b1;
                            end
                        end else if (wcnt_reg == LEN) begin
                            valid_next   = 1'b1;
                            eop_next     = 1'b1;
                            restart_next = 1'b1;
                            cnt_inc[2]   = 1'b1;
                            state_next   = DROP;
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            state_next = IDLE;
                            wcnt_next  = '0;
                        end
                    end
                    default: ;
                endcase
            end

            if (hdr_beat) begin
                wcnt_next  = idx_inc;
                state_next = HDR;
                if (idx == FIELD_IDX) begin
                    if (sd_ready) begin
                        rec_next   = field_rec;
                        valid_next = 1'b1;
                        sop_next   = 1'b1;
                        state_next = BODY;
                        if (in_eop) begin
                            eop_next   = 1'b1;
                            state_next = IDLE;
                            wcnt_next  = '0;
                            if (idx_inc == LEN) begin
                                cnt_inc[0] = 1'b1;
                            end else begin
                                restart_next = 1'b1;
                                cnt_inc[2]   = 1'b1;
                            end
                        end
                    end else begin
                        cnt_inc[1] = 1'b1;
                        state_next = in_eop ? IDLE : DROP;
                        if (in_eop) wcnt_next = '0;
                    end
                end else if (in_eop) begin
                    cnt_inc[2] = 1'b1;
                    state_next = IDLE;
                    wcnt_next  = '0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            sd_err_cnt #(.WIDTH(32)) u_cnt (
                .clk_wr (clk_wr),
                .rst_n  (rst_n),
                .inc    (cnt_inc[gi]),
                .count  (cnt_val[gi])
            );
        end
    endgenerate

    assign pkt_cnt    = cnt_val[0];
    assign drop_cnt   = cnt_val[1];
    assign err_cnt    = cnt_val[2];
    assign sd_valid   = valid_reg;
    assign sd_sop     = sop_reg;
    assign sd_eop     = eop_reg;
    assign sd_restart = restart_reg;
    assign sd_exp     = rec_reg.exp;
    assign sd_symbol  = rec_reg.symbol;
    assign sd_slot    = rec_reg.slot;
    assign sd_frame   = rec_reg.frame;

endmodule

// File: tb/tb_sd_extract.sv
// Directed bench for sd_extract: main instance with PKT_LEN=16 and a second
// header-only instance with PKT_LEN=2 sharing the same input stream.
module tb_sd_extract;

    logic        clk_wr = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sop, in_eop, sd_ready;
    logic [63:0] in_data;

    logic        sd_valid, sd_sop, sd_eop, sd_restart;
    logic [5:0]  sd_exp;
    logic [3:0]  sd_symbol;
    logic [7:0]  sd_slot;
    logic [9:0]  sd_frame;
    logic [31:0] pkt_cnt, drop_cnt, err_cnt;

    logic        h_valid, h_sop, h_eop, h_restart;
    logic [5:0]  h_exp;
    logic [3:0]  h_symbol;
    logic [7:0]  h_slot;
    logic [9:0]  h_frame;
    logic [31:0] h_pkt_cnt, h_drop_cnt, h_err_cnt;

    int checks   = 0;
    int failures = 0;

    // Field words: {frame, slot, symbol, exp, 36'b0}
    localparam logic [63:0] FW1   = {10'h155, 8'h3C, 4'h7, 6'h2A, 36'h0};
    localparam logic [63:0] FW2   = {10'h2AA, 8'hC3, 4'h8, 6'h15, 36'h0};
    localparam logic [63:0] OTHER = 64'hDEAD_BEEF_0123_4567;

    logic [3:0] pulses, h_pulses, exp_p;
    assign pulses   = {sd_valid, sd_sop, sd_eop, sd_restart};
    assign h_pulses = {h_valid, h_sop, h_eop, h_restart};

    always #5 clk_wr = ~clk_wr;

    sd_extract #(.PKT_LEN(16)) dut (
        .clk_wr(clk_wr), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_data(in_data), .sd_ready(sd_ready),
        .sd_valid(sd_valid), .sd_sop(sd_sop), .sd_eop(sd_eop), .sd_restart(sd_restart),
        .sd_exp(sd_exp), .sd_symbol(sd_symbol), .sd_slot(sd_slot), .sd_frame(sd_frame),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    sd_extract #(.PKT_LEN(2)) dut_h (
        .clk_wr(clk_wr), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_data(in_data), .sd_ready(sd_ready),
        .sd_valid(h_valid), .sd_sop(h_sop), .sd_eop(h_eop), .sd_restart(h_restart),
        .sd_exp(h_exp), .sd_symbol(h_symbol), .sd_slot(h_slot), .sd_frame(h_frame),
        .pkt_cnt(h_pkt_cnt), .drop_cnt(h_drop_cnt), .err_cnt(h_err_cnt)
    );

    task automatic beat(input logic sop, input logic eop, input logic [63:0] data,
                        input logic rdy);
        @(negedge clk_wr);
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = data; sd_ready = rdy;
        @(posedge clk_wr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_wr);
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            @(posedge clk_wr);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_wr);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; sd_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk_wr);
        @(negedge clk_wr);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; sd_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        checks++;
        if (pulses !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses got %b expected 0000", pulses);
        end
        checks++;
        if ({sd_frame, sd_slot, sd_symbol, sd_exp} !== 28'h0) begin
            failures++; $display("FAIL reset_fields got %h expected 0", {sd_frame, sd_slot, sd_symbol, sd_exp});
        end
        checks++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== 96'h0) begin
            failures++; $display("FAIL reset_counters got %0d/%0d/%0d expected 0/0/0", pkt_cnt, drop_cnt, err_cnt);
        end
        @(negedge clk_wr);
        rst_n = 1'b1;
        idle(1);
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 16; i++) begin
            beat(i == 0, i == 15, (i == 1) ? FW1 : OTHER, 1'b1);
            exp_p = (i == 1) ? 4'b1100 : (i == 15) ? 4'b1010 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL nominal_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
            if (i == 1) begin
                checks++;
                if ({sd_frame, sd_slot, sd_symbol, sd_exp} !== {10'h155, 8'h3C, 4'h7, 6'h2A}) begin
                    failures++; $display("FAIL nominal_fields got %h %h %h %h expected 155 3c 7 2a", sd_frame, sd_slot, sd_symbol, sd_exp);
                end
            end
        end
        checks++;
        if (pkt_cnt !== 32'd1 || err_cnt !== 32'd0) begin
            failures++; $display("FAIL nominal_counts got pkt=%0d err=%0d expected pkt=1 err=0", pkt_cnt, err_cnt);
        end
        idle(2);
        $display("test_nominal done pkt_cnt=%0d", pkt_cnt);
    endtask

    task automatic test_drop();
        for (int i = 0; i < 16; i++) begin
            beat(i == 0, i == 15, (i == 1) ? FW2 : OTHER, i != 1);
            checks++;
            if (pulses !== 4'b0000) begin
                failures++; $display("FAIL drop_quiet beat %0d got %b expected 0000", i, pulses);
            end
        end
        checks++;
        if (drop_cnt !== 32'd1 || sd_frame !== 10'h155) begin
            failures++; $display("FAIL drop_count_hold got drop=%0d frame=%h expected drop=1 frame=155", drop_cnt, sd_frame);
        end
        idle(1);
        for (int i = 0; i < 16; i++) begin
            beat(i == 0, i == 15, (i == 1) ? FW2 : OTHER, 1'b1);
            exp_p = (i == 1) ? 4'b1100 : (i == 15) ? 4'b1010 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL after_drop_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
        end
        checks++;
        if ({sd_frame, sd_slot, sd_symbol, sd_exp} !== {10'h2AA, 8'hC3, 4'h8, 6'h15} || pkt_cnt !== 32'd2) begin
            failures++; $display("FAIL after_drop_fields got %h %h %h %h pkt=%0d expected 2aa c3 8 15 pkt=2", sd_frame, sd_slot, sd_symbol, sd_exp, pkt_cnt);
        end
        idle(2);
        $display("test_drop done drop_cnt=%0d pkt_cnt=%0d", drop_cnt, pkt_cnt);
    endtask

    task automatic test_short_long();
        for (int i = 0; i < 10; i++) begin
            beat(i == 0, i == 9, (i == 1) ? FW1 : OTHER, 1'b1);
            exp_p = (i == 1) ? 4'b1100 : (i == 9) ? 4'b1011 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL short_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
        end
        checks++;
        if (err_cnt !== 32'd1 || pkt_cnt !== 32'd2) begin
            failures++; $display("FAIL short_counts got err=%0d pkt=%0d expected err=1 pkt=2", err_cnt, pkt_cnt);
        end
        idle(1);
        for (int i = 0; i < 20; i++) begin
            beat(i == 0, i == 19, (i == 1) ? FW1 : OTHER, 1'b1);
            exp_p = (i == 1) ? 4'b1100 : (i == 16) ? 4'b1011 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL long_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
        end
        checks++;
        if (err_cnt !== 32'd2 || pkt_cnt !== 32'd2) begin
            failures++; $display("FAIL long_counts got err=%0d pkt=%0d expected err=2 pkt=2", err_cnt, pkt_cnt);
        end
        idle(1);
        beat(1'b1, 1'b1, FW1, 1'b1);
        checks++;
        if (pulses !== 4'b0000 || err_cnt !== 32'd3) begin
            failures++; $display("FAIL hdr_eop got pulses=%b err=%0d expected 0000 err=3", pulses, err_cnt);
        end
        idle(2);
        $display("test_short_long done err_cnt=%0d", err_cnt);
    endtask

    task automatic test_missing_eop();
        for (int i = 0; i < 5; i++) begin
            beat(i == 0, 1'b0, (i == 1) ? FW2 : OTHER, 1'b1);
            exp_p = (i == 1) ? 4'b1100 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL abort_first_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
        end
        for (int i = 0; i < 16; i++) begin
            beat(i == 0, i == 15, (i == 1) ? FW1 : OTHER, 1'b1);
            exp_p = (i == 0) ? 4'b0001 : (i == 1) ? 4'b1100 : (i == 15) ? 4'b1010 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL abort_second_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
        end
        checks++;
        if (err_cnt !== 32'd4 || pkt_cnt !== 32'd3 || sd_frame !== 10'h155) begin
            failures++; $display("FAIL abort_counts got err=%0d pkt=%0d frame=%h expected err=4 pkt=3 frame=155", err_cnt, pkt_cnt, sd_frame);
        end
        idle(2);
        $display("test_missing_eop done err_cnt=%0d pkt_cnt=%0d", err_cnt, pkt_cnt);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) beat(i == 0, 1'b0, (i == 1) ? FW2 : OTHER, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pulses !== 4'b0000 || {sd_frame, sd_slot, sd_symbol, sd_exp} !== 28'h0 ||
            {pkt_cnt, drop_cnt, err_cnt} !== 96'h0) begin
            failures++; $display("FAIL reset_mid got pulses=%b frame=%h pkt=%0d err=%0d expected all 0", pulses, sd_frame, pkt_cnt, err_cnt);
        end
        @(negedge clk_wr);
        in_valid = 1'b0;
        @(negedge clk_wr);
        rst_n = 1'b1;
        beat(1'b0, 1'b0, FW1, 1'b1);
        beat(1'b0, 1'b1, FW1, 1'b1);
        checks++;
        if (pulses !== 4'b0000 || err_cnt !== 32'd0 || sd_frame !== 10'h0) begin
            failures++; $display("FAIL reset_ignore got pulses=%b err=%0d frame=%h expected 0000 0 000", pulses, err_cnt, sd_frame);
        end
        for (int i = 0; i < 16; i++) begin
            beat(i == 0, i == 15, (i == 1) ? FW2 : OTHER, 1'b1);
            exp_p = (i == 1) ? 4'b1100 : (i == 15) ? 4'b1010 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                failures++; $display("FAIL reset_resume_pulses beat %0d got %b expected %b", i, pulses, exp_p);
            end
        end
        checks++;
        if (pkt_cnt !== 32'd1 || err_cnt !== 32'd0 || sd_frame !== 10'h2AA) begin
            failures++; $display("FAIL reset_resume_counts got pkt=%0d err=%0d frame=%h expected 1 0 2aa", pkt_cnt, err_cnt, sd_frame);
        end
        idle(2);
        $display("test_reset_mid done pkt_cnt=%0d", pkt_cnt);
    endtask

    task automatic test_header_only();
        do_reset();
        beat(1'b1, 1'b0, OTHER, 1'b1);
        checks++;
        if (h_pulses !== 4'b0000) begin
            failures++; $display("FAIL hdr_only_word0 got %b expected 0000", h_pulses);
        end
        beat(1'b0, 1'b1, FW1, 1'b1);
        checks++;
        if (h_pulses !== 4'b1110) begin
            failures++; $display("FAIL hdr_only_pulses got %b expected 1110", h_pulses);
        end
        checks++;
        if (h_pkt_cnt !== 32'd1 || h_err_cnt !== 32'd0 || {h_frame, h_slot, h_symbol, h_exp} !== {10'h155, 8'h3C, 4'h7, 6'h2A}) begin
            failures++; $display("FAIL hdr_only_counts got pkt=%0d err=%0d frame=%h expected 1 0 155", h_pkt_cnt, h_err_cnt, h_frame);
        end
        idle(1);
        checks++;
        if (h_pulses !== 4'b0000) begin
            failures++; $display("FAIL hdr_only_single got %b expected 0000", h_pulses);
        end
        $display("test_header_only done pkt_cnt=%0d", h_pkt_cnt);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_drop();
        test_short_long();
        test_missing_eop();
        test_reset_mid();
        test_header_only();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
